// File: rtl/xctcmsg_receive_matcher_if.sv
// Message types plus the net / receive-queue / writeback handshake bundle for the
// receive matcher. The package is kept here so the bundle compiles from two files.
package xctcmsg_pkg;
    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] addr;
        logic [63:0] data;
    } interface_receive_data_t;

    // meta/meta_mask are laid out as {tag, addr}
    typedef struct packed {
        logic        is_avail;
        logic [63:0] meta;
        logic [63:0] meta_mask;
        logic [7:0]  passthrough;
    } receive_queue_data_t;

    typedef struct packed {
        logic [63:0] value;
        logic [7:0]  passthrough;
    } writeback_arbiter_data_t;
endpackage

interface xctcmsg_receive_matcher_if
    import xctcmsg_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    localparam int COUNT_WIDTH = $clog2(BUFFER_DEPTH + 1)
) ();
    logic                    net_valid_i;
    logic                    net_ready_o;
    interface_receive_data_t net_data_i;
    logic                    rq_valid_i;
    logic                    rq_ready_o;
    receive_queue_data_t     rq_data_i;
    logic                    wb_valid_o;
    logic                    wb_ready_i;
    writeback_arbiter_data_t wb_data_o;
    logic [COUNT_WIDTH-1:0]  buffer_count_o;

    modport master (
        output net_valid_i, net_data_i, rq_valid_i, rq_data_i, wb_ready_i,
        input  net_ready_o, rq_ready_o, wb_valid_o, wb_data_o, buffer_count_o
    );
    modport slave (
        input  net_valid_i, net_data_i, rq_valid_i, rq_data_i, wb_ready_i,
        output net_ready_o, rq_ready_o, wb_valid_o, wb_data_o, buffer_count_o
    );
endinterface

// File: rtl/xctcmsg_receive_matcher.sv
// Arrival-ordered compacting message buffer serving one receive-queue request at a
// time: RECV removes the oldest masked match and returns its data, AVAIL reports presence.
module xctcmsg_receive_matcher
    import xctcmsg_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    localparam int COUNT_WIDTH = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    xctcmsg_receive_matcher_if.slave      bus
);
    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_RESP} state_t;

    state_t                  r_state;
    interface_receive_data_t r_buf [BUFFER_DEPTH];
    logic [COUNT_WIDTH-1:0]  r_count;
    receive_queue_data_t     r_req;
    logic                    r_rq_ready;
    logic                    r_wb_valid;
    writeback_arbiter_data_t r_wb_data;

    logic                    w_net_ready;
    logic                    w_push;
    logic                    w_rm;
    logic                    w_any;
    logic [COUNT_WIDTH-1:0]  w_sel;
    logic [COUNT_WIDTH-1:0]  w_wr_idx;
    logic [63:0]             w_sel_data;

    // Scan from the top down so the last hit written is the oldest match.
    always_comb begin
        w_any      = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        for (int i = BUFFER_DEPTH - 1; i >= 0; i--) begin
            if (i < int'(r_count) &&
                ((({r_buf[i].tag, r_buf[i].addr} ^ r_req.meta) & r_req.meta_mask) == 64'd0)) begin
                w_any      = 1'b1;
                w_sel      = COUNT_WIDTH'(i);
                w_sel_data = r_buf[i].data;
            end
        end
    end

    assign w_net_ready = (r_count < COUNT_WIDTH'(BUFFER_DEPTH));
    assign w_push      = bus.net_valid_i && w_net_ready;
    assign w_rm        = (r_state == S_MATCH) && !r_req.is_avail && w_any;
    assign w_wr_idx    = r_count - COUNT_WIDTH'(w_rm);

    // Entries beyond r_count are don't-care, so the payload array needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUFFER_DEPTH - 1; i++) begin
            if (w_rm && i >= int'(w_sel))
                r_buf[i] <= r_buf[i + 1];
        end
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            if (w_push && i == int'(w_wr_idx))
                r_buf[i] <= bus.net_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_req      <= '0;
            r_rq_ready <= 1'b1;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            r_count <= r_count - COUNT_WIDTH'(w_rm) + COUNT_WIDTH'(w_push);
            case (r_state)
                S_IDLE: begin
                    if (bus.rq_valid_i) begin
                        r_req      <= bus.rq_data_i;
                        r_rq_ready <= 1'b0;
                        r_state    <= S_MATCH;
                    end
                end
                S_MATCH: begin
                    if (r_req.is_avail) begin
                        r_wb_data  <= '{value: w_any ? 64'd1 : 64'd0, passthrough: r_req.passthrough};
                        r_wb_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (w_any) begin
                        r_wb_data  <= '{value: w_sel_data, passthrough: r_req.passthrough};
                        r_wb_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.wb_ready_i) begin
                        r_wb_valid <= 1'b0;
                        r_rq_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.net_ready_o    = w_net_ready;
    assign bus.rq_ready_o     = r_rq_ready;
    assign bus.wb_valid_o     = r_wb_valid;
    assign bus.wb_data_o      = r_wb_data;
    assign bus.buffer_count_o = r_count;
endmodule
